// File: rtl/shift_cmd_sequencer.sv
// Command front-end for an N-bit combinational barrel shifter: FIFO-buffered
// requests, multi-pass execution for large amounts, registered result stage.
module shift_cmd_sequencer #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_data,
  input  logic [$clog2(N):0]       in_amt,
  input  logic                     in_dir,
  output logic [N-1:0]             sh_data,
  output logic [$clog2(N)-1:0]     sh_amt,
  output logic                     sh_dir,
  input  logic [N-1:0]             sh_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = N + AW + 2;
  localparam logic [AW:0] MAX_PASS   = (AW+1)'(N - 1);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    EXEC
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];
  logic [N-1:0]    work_data_q, work_data_d;
  logic [AW:0]     rem_q, rem_d;
  logic            work_dir_q, work_dir_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    out_data_q, out_data_d;

  logic            push;
  logic            pop;
  logic [EW-1:0]   head;
  logic [N-1:0]    head_data;
  logic [AW:0]     head_amt;
  logic            head_dir;

  assign in_ready   = (count_q < FULL_COUNT);
  assign push       = in_valid && in_ready;
  assign fifo_count = count_q;
  assign busy       = (state_q == EXEC);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  assign head      = mem_q[rd_ptr_q];
  assign head_data = head[EW-1 -: N];
  assign head_amt  = head[AW+1:1];
  assign head_dir  = head[0];

  // Shifter drive comes straight from the working registers; since they are
  // held in IDLE, the shifter inputs stay at their last EXEC values there.
  assign sh_data = work_data_q;
  assign sh_dir  = work_dir_q;
  assign sh_amt  = (rem_q > MAX_PASS) ? AW'(N - 1) : rem_q[AW-1:0];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_data, in_amt, in_dir};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
  end

  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // A pop is only allowed when the output register is free (or being drained
  // this cycle), so a completion can never overwrite unconsumed data.
  always_comb begin
    state_d     = state_q;
    work_data_d = work_data_q;
    rem_d       = rem_q;
    work_dir_d  = work_dir_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && (!out_valid_q || out_ready)) begin
          pop         = 1'b1;
          work_data_d = head_data;
          rem_d       = head_amt;
          work_dir_d  = head_dir;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (rem_q > MAX_PASS) begin
          work_data_d = sh_result;
          rem_d       = rem_q - MAX_PASS;
        end else begin
          out_data_d  = sh_result;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      work_data_q <= '0;
      rem_q       <= '0;
      work_dir_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      work_data_q <= work_data_d;
      rem_q       <= rem_d;
      work_dir_q  <= work_dir_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Self-checking bench for shift_cmd_sequencer with a behavioural barrel shifter
// and a scoreboard of expected results in acceptance order.
module tb_shift_cmd_sequencer;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_amt;
  logic       in_dir;
  logic [7:0] sh_data;
  logic [2:0] sh_amt;
  logic       sh_dir;
  logic [7:0] sh_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic [2:0] fifo_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       rand_rdy = 1'b0;

  shift_cmd_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_dir(in_dir),
    .sh_data(sh_data), .sh_amt(sh_amt), .sh_dir(sh_dir), .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  assign sh_result = sh_dir ? (sh_data >> sh_amt) : (sh_data << sh_amt);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [3:0] a, input logic dr);
    if (a >= 4'd8) return 8'h00;
    return dr ? (d >> a) : (d << a);
  endfunction

  // scoreboard: push on accept, pop/compare on output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(ref_shift(in_data, in_amt, in_dir));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
        else check("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] a, input logic dr);
    int n;
    in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dr;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy || out_valid || fifo_count != 0) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic trace_cmd(input string tag, input logic [7:0] d, input logic [3:0] a, input logic dr);
    logic [2:0] exp_amt[$];
    int rem, step, busy_n, ov_n, first_ov;
    rem = a;
    do begin
      step = (rem > 7) ? 7 : rem;
      exp_amt.push_back(3'(step));
      rem -= step;
    end while (rem > 0);
    send(d, a, dr);
    busy_n = 0; ov_n = 0; first_ov = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy) begin
        if (busy_n < exp_amt.size()) begin
          check({tag, "_sh_amt"}, sh_amt, exp_amt[busy_n]);
          check({tag, "_sh_dir"}, sh_dir, dr);
        end
        busy_n++;
      end
      if (out_valid) begin
        if (first_ov < 0) begin
          first_ov = k;
          check({tag, "_out_data"}, out_data, ref_shift(d, a, dr));
        end
        ov_n++;
      end
    end
    check({tag, "_busy_cycles"}, busy_n, exp_amt.size());
    check({tag, "_latency"}, first_ov, 1 + exp_amt.size());
    check({tag, "_valid_width"}, ov_n, 1);
    tick();
  endtask

  initial begin
    int n, seen;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_dir = 1'b0; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sh_data", sh_data, 0);
    check("rst_sh_amt", sh_amt, 0);
    check("rst_sh_dir", sh_dir, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // single pass, multi-pass, three-pass
    trace_cmd("b5_l3", 8'hB5, 4'd3, 1'b0);
    trace_cmd("81_r9", 8'h81, 4'd9, 1'b1);
    trace_cmd("ff_l15", 8'hFF, 4'd15, 1'b0);
    trace_cmd("c3_r0", 8'hC3, 4'd0, 1'b1);
    trace_cmd("f0_r7", 8'hF0, 4'd7, 1'b1);
    drain();

    // backpressure: fill output register and FIFO, sixth held
    out_ready = 1'b0;
    send(8'h11, 4'd1, 1'b0);
    send(8'h22, 4'd2, 1'b1);
    send(8'h33, 4'd3, 1'b0);
    send(8'h44, 4'd4, 1'b1);
    send(8'h55, 4'd5, 1'b0);
    in_valid = 1'b1; in_data = 8'h66; in_amt = 4'd6; in_dir = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    check("bp_out_valid", out_valid, 1);
    check("bp_busy", busy, 0);
    check("bp_fifo_count", fifo_count, 4);
    check("bp_in_ready", in_ready, 0);
    tick();
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_sixth_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    drain();

    // simultaneous push and pop at count 2
    out_ready = 1'b0;
    send(8'h0F, 4'd2, 1'b0);
    send(8'hF0, 4'd3, 1'b1);
    send(8'hAA, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    check("pp_count_before", fifo_count, 2);
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h5A; in_amt = 4'd4; in_dir = 1'b1;
    @(negedge clk);
    check("pp_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("pp_count_after", fifo_count, 2);
    tick();
    drain();

    // reset during pass 2 of an amt-15 command with three queued
    out_ready = 1'b0;
    send(8'h3C, 4'd1, 1'b0);
    send(8'hFF, 4'd15, 1'b0);
    send(8'h12, 4'd2, 1'b1);
    send(8'h34, 4'd3, 1'b0);
    send(8'h56, 4'd4, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    check("rs_count_full", fifo_count, 4);
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rs_pass2_busy", busy, 1);
    check("rs_pass2_amt", sh_amt, 7);
    check("rs_pass2_count", fifo_count, 3);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rs_out_valid", out_valid, 0);
    check("rs_fifo_count", fifo_count, 0);
    check("rs_busy", busy, 0);
    check("rs_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rs_no_result", seen, 0);
    tick();

    // random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_rdy = 1'b0;
    tick();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
